reg_file_sb: RTL and testbench

//  Parametrised 2-read/1-write register file with an integrated busy-bit scoreboard.
//  - Sits in the decode/writeback stage of the RISC core.
//  - Read data is registered, with write-to-read bypass.
//  - The optional hardwired-zero register serves RISC-style ISAs.
//  - Per-register busy flags let decode detect RAW hazards against in-flight results.

---
 rtl/reg_file_sb.sv | 152 +++++++++++++++
 tb/tb_reg_file_sb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Two-read / one-write register file with a per-register busy scoreboard,
// used in the decode/writeback stage of the core. All state changes on the
// FALLING edge of I_clk. Reset is synchronous and active low, and it overrides
// every other input.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   select width, DEPTH = 2**ADDR_W
//   ZERO_REG 1: register 0 is hardwired zero and never busy
//   BYPASS   1: same-edge writeback data is forwarded to the read outputs
//
// Ports
//   I_clk, I_rst_n, I_en          clock, sync reset (low), global enable
//   I_we, I_selD, I_dataD         writeback (also clears busy of I_selD)
//   I_selA, I_selB                read selects
//   I_rsv, I_selR                 reserve: mark I_selR busy
//   o_dataA/B, o_busyA/B          registered read data / operand-pending
//   o_hazard                      o_busyA | o_busyB
//   o_busy_vec                    stored busy flags, bit i = register i
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     I_clk,
    input  logic                     I_rst_n,
    input  logic                     I_en,
    input  logic                     I_we,
    input  logic [ADDR_W-1:0]        I_selD,
    input  logic [DATA_W-1:0]        I_dataD,
    input  logic [ADDR_W-1:0]        I_selA,
    input  logic [ADDR_W-1:0]        I_selB,
    input  logic                     I_rsv,
    input  logic [ADDR_W-1:0]        I_selR,
    output logic [DATA_W-1:0]        o_dataA,
    output logic [DATA_W-1:0]        o_dataB,
    output logic                     o_busyA,
    output logic                     o_busyB,
    output logic                     o_hazard,
    output logic [(1<<ADDR_W)-1:0]   o_busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DEPTH-1:0]  ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] SEL_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DATA_W-1:0] r_dataA;
    logic [DATA_W-1:0] r_dataB;
    logic              r_busyA;
    logic              r_busyB;

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic              w_zero_a;
    logic              w_zero_b;
    logic              w_hit_a;
    logic              w_hit_b;
    logic [DEPTH-1:0]  w_clr_mask;
    logic [DEPTH-1:0]  w_set_mask;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [DATA_W-1:0] w_dataA_nxt;
    logic [DATA_W-1:0] w_dataB_nxt;
    logic              w_busyA_nxt;
    logic              w_busyB_nxt;

    // Qualify write/reserve (dropped on the hardwired-zero register) and detect read hits
    always_comb begin
        w_wr_ok  = I_we  && !((ZERO_REG != 0) && (I_selD == SEL_ZERO));
        w_rsv_ok = I_rsv && !((ZERO_REG != 0) && (I_selR == SEL_ZERO));
        w_zero_a = (ZERO_REG != 0) && (I_selA == SEL_ZERO);
        w_zero_b = (ZERO_REG != 0) && (I_selB == SEL_ZERO);
        w_hit_a  = w_wr_ok && (I_selD == I_selA);
        w_hit_b  = w_wr_ok && (I_selD == I_selB);
    end

    // Next busy vector: set is applied after clear so a same-register reserve wins
    always_comb begin
        w_clr_mask = w_wr_ok  ? (ONE_HOT0 << I_selD) : {DEPTH{1'b0}};
        w_set_mask = w_rsv_ok ? (ONE_HOT0 << I_selR) : {DEPTH{1'b0}};
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    // Read port A: the same-edge reservation is deliberately not visible here
    always_comb begin
        w_dataA_nxt = r_regs[I_selA];
        w_busyA_nxt = r_busy[I_selA];
        if (w_zero_a) begin
            w_dataA_nxt = DATA_ZERO;
            w_busyA_nxt = 1'b0;
        end else if (w_hit_a) begin
            w_dataA_nxt = (BYPASS != 0) ? I_dataD : r_regs[I_selA];
            w_busyA_nxt = 1'b0;
        end else begin
            w_dataA_nxt = r_regs[I_selA];
            w_busyA_nxt = r_busy[I_selA];
        end
    end

    // Read port B: identical rules to port A
    always_comb begin
        w_dataB_nxt = r_regs[I_selB];
        w_busyB_nxt = r_busy[I_selB];
        if (w_zero_b) begin
            w_dataB_nxt = DATA_ZERO;
            w_busyB_nxt = 1'b0;
        end else if (w_hit_b) begin
            w_dataB_nxt = (BYPASS != 0) ? I_dataD : r_regs[I_selB];
            w_busyB_nxt = 1'b0;
        end else begin
            w_dataB_nxt = r_regs[I_selB];
            w_busyB_nxt = r_busy[I_selB];
        end
    end

    // State and output registers, falling-edge clocked, reset overrides enable
    always_ff @(negedge I_clk) begin
        if (!I_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= DATA_ZERO;
            end
            r_busy  <= {DEPTH{1'b0}};
            r_dataA <= DATA_ZERO;
            r_dataB <= DATA_ZERO;
            r_busyA <= 1'b0;
            r_busyB <= 1'b0;
        end else if (I_en) begin
            if (w_wr_ok) begin
                r_regs[I_selD] <= I_dataD;
            end
            r_busy  <= w_busy_nxt;
            r_dataA <= w_dataA_nxt;
            r_dataB <= w_dataB_nxt;
            r_busyA <= w_busyA_nxt;
            r_busyB <= w_busyB_nxt;
        end
    end

    assign o_dataA    = r_dataA;
    assign o_dataB    = r_dataB;
    assign o_busyA    = r_busyA;
    assign o_busyB    = r_busyB;
    assign o_hazard   = r_busyA | r_busyB;
    assign o_busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Three instances share one stimulus stream:
//   dut0: ZERO_REG=0, BYPASS=1   dut1: ZERO_REG=1, BYPASS=1   dut2: ZERO_REG=0, BYPASS=0
// The stimulus drives inputs just after each rising edge, so the DUT samples them
// on the following falling edge. A reference model computes the post-edge outputs
// and queues them. A monitor pops and compares on each rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    typedef struct packed {
        logic [15:0] dA;
        logic [15:0] dB;
        logic        bA;
        logic        bB;
        logic        hz;
        logic [7:0]  bv;
    } exp_t;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_en = 1'b1;
    logic        I_we = 1'b0;
    logic [2:0]  I_selD = 3'd0;
    logic [15:0] I_dataD = 16'd0;
    logic [2:0]  I_selA = 3'd0;
    logic [2:0]  I_selB = 3'd0;
    logic        I_rsv = 1'b0;
    logic [2:0]  I_selR = 3'd0;

    logic [15:0] dA [3];
    logic [15:0] dB [3];
    logic        bA [3];
    logic        bB [3];
    logic        hz [3];
    logic [7:0]  bv [3];

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_we(I_we),
        .I_selD(I_selD), .I_dataD(I_dataD), .I_selA(I_selA), .I_selB(I_selB),
        .I_rsv(I_rsv), .I_selR(I_selR),
        .o_dataA(dA[0]), .o_dataB(dB[0]), .o_busyA(bA[0]), .o_busyB(bB[0]),
        .o_hazard(hz[0]), .o_busy_vec(bv[0]));

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut1 (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_we(I_we),
        .I_selD(I_selD), .I_dataD(I_dataD), .I_selA(I_selA), .I_selB(I_selB),
        .I_rsv(I_rsv), .I_selR(I_selR),
        .o_dataA(dA[1]), .o_dataB(dB[1]), .o_busyA(bA[1]), .o_busyB(bB[1]),
        .o_hazard(hz[1]), .o_busy_vec(bv[1]));

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut2 (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_we(I_we),
        .I_selD(I_selD), .I_dataD(I_dataD), .I_selA(I_selA), .I_selB(I_selB),
        .I_rsv(I_rsv), .I_selR(I_selR),
        .o_dataA(dA[2]), .o_dataB(dB[2]), .o_busyA(bA[2]), .o_busyB(bB[2]),
        .o_hazard(hz[2]), .o_busy_vec(bv[2]));

    always #5 I_clk = ~I_clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state, one copy per instance
    logic [15:0] m_mem [3][8];
    logic [7:0]  m_busy [3];
    exp_t        m_out [3];

    task automatic cmp(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: each falling edge produced one result per instance, checked at the next rising edge
    always @(posedge I_clk) begin
        exp_t e;
        if (exp_q.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                e = exp_q.pop_front();
                cmp("dataA", k, dA[k], e.dA);
                cmp("dataB", k, dB[k], e.dB);
                cmp("busyA", k, 16'(bA[k]), 16'(e.bA));
                cmp("busyB", k, 16'(bB[k]), 16'(e.bB));
                cmp("hazard", k, 16'(hz[k]), 16'(e.hz));
                cmp("busy_vec", k, 16'(bv[k]), 16'(e.bv));
            end
        end
    end

    // Architectural read of one port: what the operand looks like after this edge
    task automatic model_read(input int k, input bit z, input bit bp, input bit wr,
                              input logic [2:0] sel, output logic [15:0] d, output logic b);
        if (z && sel == 3'd0) begin
            d = 16'd0;
            b = 1'b0;
        end else if (wr && I_selD == sel) begin
            d = bp ? I_dataD : m_mem[k][sel];
            b = 1'b0;
        end else begin
            d = m_mem[k][sel];
            b = m_busy[k][sel];
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit z;
            bit bp;
            bit wr;
            bit rv;
            logic [15:0] d;
            logic        b;
            z = (k == 1);
            bp = (k != 2);
            if (!I_rst_n) begin
                for (int i = 0; i < 8; i++) m_mem[k][i] = 16'd0;
                m_busy[k] = 8'd0;
                m_out[k] = '0;
            end else if (I_en) begin
                wr = I_we && !(z && I_selD == 3'd0);
                rv = I_rsv && !(z && I_selR == 3'd0);
                model_read(k, z, bp, wr, I_selA, d, b);
                m_out[k].dA = d;
                m_out[k].bA = b;
                model_read(k, z, bp, wr, I_selB, d, b);
                m_out[k].dB = d;
                m_out[k].bB = b;
                if (wr) begin
                    m_mem[k][I_selD] = I_dataD;
                    m_busy[k][I_selD] = 1'b0;
                end
                if (rv) m_busy[k][I_selR] = 1'b1;
                m_out[k].hz = m_out[k].bA | m_out[k].bB;
                m_out[k].bv = m_busy[k];
            end
            exp_q.push_back(m_out[k]);
        end
    endtask

    task automatic step(input logic rst_n, input logic en, input logic we, input logic [2:0] sd,
                        input logic [15:0] dd, input logic [2:0] sa, input logic [2:0] sb,
                        input logic rsv, input logic [2:0] sr);
        @(posedge I_clk);
        #1;
        I_rst_n = rst_n; I_en = en; I_we = we; I_selD = sd; I_dataD = dd;
        I_selA = sa; I_selB = sb; I_rsv = rsv; I_selR = sr;
        model_edge();
    endtask

    initial begin
        logic [2:0] sd;
        // 1: reset with enable high, then read every register on both ports
        step(1'b0, 1'b1, 1'b1, 3'd3, 16'hAAAA, 3'd0, 3'd0, 1'b1, 3'd3);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'(i), 3'(7 - i), 1'b0, 3'd0);
        // 2: write then read; same-edge write with bypass
        step(1'b1, 1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd3, 3'd3, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd3, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd5, 3'd5, 1'b0, 3'd0);
        // 3: register 0 write + reserve + read on both ports
        step(1'b1, 1'b1, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b0, 3'd0);
        // 4: reserve r2, hazard, then writeback r2 while reading it
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd1, 3'd1, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd2, 3'd1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd2, 16'h5A5A, 3'd2, 3'd2, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd2, 3'd2, 1'b0, 3'd0);
        // 5: write and reserve r4 together, then three disabled edges with writes
        step(1'b1, 1'b1, 1'b1, 3'd4, 16'hC0DE, 3'd4, 3'd3, 1'b1, 3'd4);
        step(1'b1, 1'b0, 1'b1, 3'd4, 16'h1111, 3'd4, 3'd5, 1'b1, 3'd6);
        step(1'b1, 1'b0, 1'b1, 3'd3, 16'h2222, 3'd3, 3'd4, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 3'd5, 16'h3333, 3'd5, 3'd2, 1'b1, 3'd1);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd4, 3'd3, 1'b0, 3'd0);
        // 6: busy on r1/r6, reset mid-stream, then a plain write to a cleared register
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd1, 3'd6, 1'b1, 3'd1);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd1, 3'd6, 1'b1, 3'd6);
        step(1'b0, 1'b0, 1'b1, 3'd1, 16'h7777, 3'd1, 3'd6, 1'b1, 3'd6);
        step(1'b1, 1'b1, 1'b1, 3'd1, 16'h4321, 3'd6, 3'd3, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 3'd1, 3'd6, 1'b0, 3'd0);
        // Randomized traffic with collisions biased in
        for (int n = 0; n < 400; n++) begin
            sd = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)), sd, 16'($urandom),
                 ($urandom_range(0, 2) == 0) ? sd : 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0) ? sd : 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0) ? sd : 3'($urandom_range(0, 7)));
        end
        @(posedge I_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
